serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one full-adder cell plus a carry flip-flop.
- Processes one bit per clock, LSB first.
- Sits in the datapath between operand registers and result consumers; trades area for WIDTH cycles of latency.
- Uses a start/busy/done handshake so a controller can launch one addition at a time.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only while busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result; holds the last completed value.
- cout  output  1  carry-out of the MSB; holds the last completed value.

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears the internal shift registers, carry flop and bit counter. Reset takes priority over all other inputs, including in mid-operation; any partial result is discarded and sum/cout read 0.
- State machine: IDLE, RUN.
- IDLE, start=1 at an edge:
  - capture a and b into internal shift registers;
  - load the carry flop with cin;
  - clear the bit counter;
  - go to RUN, busy=1.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry;
  - c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  - shift s into the MSB of the internal result register (right shift);
  - shift a_sh and b_sh right by one;
  - carry <= c;
  - counter increments.
- Completion: on the edge that processes bit WIDTH-1:
  - copy the completed result register to sum and the final carry to cout;
  - done=1 for exactly that following cycle;
  - busy=0, go to IDLE.
- Latency: the accepting edge is edge 0. sum/cout are valid and done=1 after edge WIDTH, i.e. WIDTH cycles after acceptance. Throughput is one addition per WIDTH+1 cycles when start is held high.
- Output stability: sum/cout do not change during RUN. They update only at completion or reset.
- Start while busy=1 is ignored; no queuing and no effect on the running operation.
- a, b and cin may change freely after the accepting edge without affecting the result.
- Start in the done cycle: busy=0, so start is accepted on that edge. done drops next cycle and the new operation begins; back-to-back is legal.
- Arithmetic: {cout, sum} = a + b + cin, unsigned, exact over WIDTH+1 bits; no overflow flag.
- WIDTH=1: RUN lasts one cycle, so done follows acceptance by one cycle. The result equals the one-bit full-adder truth table.
- Bit counter width is clog2(WIDTH)+1. It must not wrap before WIDTH-1 is reached for any legal WIDTH.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed one cycle -> busy high for 8 cycles; done pulses at cycle 8 after acceptance; sum=0x96, cout=0.
2. WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. sum stays at the previous value throughout each RUN.
3. Start 0x10+0x20; at cycle 3 of RUN, pulse start with a=0xAA, b=0x55 and change the a/b inputs -> request ignored; result is sum=0x30, cout=0; done fires exactly once.
4. start held high continuously with new operands at each done cycle: 0x01+0x02, then 0x80+0x80 -> results 0x03/0 then 0x00/1. The second done arrives 9 cycles after the first.
5. Start 0xF0+0x0F, assert rst at cycle 4 of RUN for one cycle -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse follows; a fresh start then completes normally.
6. WIDTH=1, all 8 combinations of a, b, cin -> {cout,sum} = 00,01,01,10,01,10,10,11 for abc = 000..111. done follows acceptance by one cycle each time.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder cell, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic {IDLE, RUN} state_t;

  // One extra counter bit keeps the compare against WIDTH-1 wrap-free for any WIDTH.
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH:0]   res_cat;

  // Full-adder cell on the current LSBs; the new sum bit enters the result MSB.
  always_comb begin
    bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    bit_c   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    res_cat = {bit_s, res_q};
  end

  // Next-state and datapath control; outputs only move at completion.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = res_cat[WIDTH:1];
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_cat[WIDTH:1];
          cout_d  = bit_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over everything, including a running add.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Waits for done, checking busy and that sum/cout hold their old value meanwhile.
  task automatic wait_done8(input int exp_lat, input logic [7:0] hold_s, input logic hold_c,
                            input string tag);
    int lat;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      check({tag, "_busy"}, busy8, 1);
      check({tag, "_hold_sum"}, sum8, hold_s);
      check({tag, "_hold_cout"}, cout8, hold_c);
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done_busy"}, busy8, 0);
  endtask

  logic [1:0] fa_tbl [8];
  logic [2:0] abc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    fa_tbl   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);

    // Test 1: 0x5A + 0x3C
    launch8(8'h5A, 8'h3C, 1'b0);
    wait_done8(8, 8'h00, 1'b0, "t1");
    check("t1_sum", sum8, 8'h96);
    check("t1_cout", cout8, 0);
    tick();
    check("t1_done_drop", done8, 0);

    // Test 2: carry-out cases
    launch8(8'hFF, 8'h01, 1'b0);
    wait_done8(8, 8'h96, 1'b0, "t2a");
    check("t2a_sum", sum8, 8'h00);
    check("t2a_cout", cout8, 1);
    tick();
    launch8(8'hFF, 8'hFF, 1'b1);
    wait_done8(8, 8'h00, 1'b1, "t2b");
    check("t2b_sum", sum8, 8'hFF);
    check("t2b_cout", cout8, 1);
    tick();

    // Test 3: start during RUN is ignored, operand changes have no effect
    launch8(8'h10, 8'h20, 1'b0);
    tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(5, 8'hFF, 1'b1, "t3");
    check("t3_sum", sum8, 8'h30);
    check("t3_cout", cout8, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_no_second_done", done8, 0);
      check("t3_idle", busy8, 0);
    end

    // Test 4: start held high, back-to-back
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    tick();
    wait_done8(8, 8'h30, 1'b0, "t4a");
    check("t4a_sum", sum8, 8'h03);
    check("t4a_cout", cout8, 0);
    a8 = 8'h80; b8 = 8'h80;
    tick();
    check("t4_done_drop", done8, 0);
    check("t4_reaccept_busy", busy8, 1);
    wait_done8(8, 8'h03, 1'b0, "t4b");
    start8 = 1'b0;
    check("t4b_sum", sum8, 8'h00);
    check("t4b_cout", cout8, 1);
    tick();
    check("t4_idle", busy8, 0);

    // Test 5: reset mid-operation
    launch8(8'hF0, 8'h0F, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy8, 0);
    check("t5_done", done8, 0);
    check("t5_sum", sum8, 0);
    check("t5_cout", cout8, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_no_done", done8, 0);
    end
    launch8(8'h12, 8'h34, 1'b0);
    wait_done8(8, 8'h00, 1'b0, "t5b");
    check("t5b_sum", sum8, 8'h46);
    check("t5b_cout", cout8, 0);

    // Test 6: WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      a1 = abc[2]; b1 = abc[1]; cin1 = abc[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("t6_busy", busy1, 1);
      check("t6_done_early", done1, 0);
      tick();
      check("t6_done", done1, 1);
      check("t6_result", {cout1, sum1}, fa_tbl[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
